// File: rtl/mc_ctl.sv
// rtl/mc_ctl.sv - multi-cycle MIPS controller; define MC_CTL_ILLEGAL_TRAP_EN to halt on illegal encodings
module mc_ctl #(
    parameter int ALU_OP_W = 4,
    parameter int EXT_OP_W = 4,
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [5:0]          opcode,
    input  logic [5:0]          func,
    input  logic                alu_zero,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    output logic                imem_req,
    output logic                dmem_req,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          npc_sel,
    output logic                reg_write,
    output logic [1:0]          reg_dst,
    output logic [1:0]          mem_to_reg,
    output logic                mem_write,
    output logic                alu_src,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [EXT_OP_W-1:0] ext_op,
    output logic [2:0]          state,
    output logic                retire,
    output logic [RETIRE_W-1:0] retire_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t                state_q;
    logic [RETIRE_W-1:0]   cnt_q;

    logic is_r, is_addu, is_subu, is_jr, is_lw, is_sw, is_ori, is_lui, is_beq, is_j, is_jal;
    logic is_alu, is_mem, is_multi, is_jump, is_nop;

    assign is_r     = (opcode == OP_RTYPE);
    assign is_addu  = is_r && (func == FN_ADDU);
    assign is_subu  = is_r && (func == FN_SUBU);
    assign is_jr    = is_r && (func == FN_JR);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_ori   = (opcode == OP_ORI);
    assign is_lui   = (opcode == OP_LUI);
    assign is_beq   = (opcode == OP_BEQ);
    assign is_j     = (opcode == OP_J);
    assign is_jal   = (opcode == OP_JAL);
    // Instructions that finish with a register write in WB
    assign is_alu   = is_addu || is_subu || is_ori || is_lui;
    assign is_mem   = is_lw || is_sw;
    assign is_multi = is_alu || is_mem || is_beq;
    assign is_jump  = is_j || is_jal || is_jr;

`ifdef MC_CTL_ILLEGAL_TRAP_EN
    logic is_sll_nop, is_illegal;
    // sll $0,$0,0 is the canonical nop and must not trap
    assign is_sll_nop = is_r && (func == 6'h00);
    assign is_illegal = !(is_multi || is_jump || is_sll_nop);
    assign is_nop     = is_sll_nop;
`else
    assign is_nop     = !(is_multi || is_jump);
`endif

    assign state      = state_q;
    assign retire_cnt = cnt_q;

    // State sequencing and retired-instruction counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            if (retire) begin
                cnt_q <= cnt_q + RETIRE_W'(1);
            end
            case (state_q)
                S_FETCH: begin
                    if (imem_ready) state_q <= S_DECODE;
                end
                S_DECODE: begin
                    if (is_multi) begin
                        state_q <= S_EXEC;
`ifdef MC_CTL_ILLEGAL_TRAP_EN
                    end else if (is_illegal) begin
                        state_q <= S_HALT;
`endif
                    end else begin
                        state_q <= S_FETCH;
                    end
                end
                S_EXEC: begin
                    if (is_mem)      state_q <= S_MEM;
                    else if (is_alu) state_q <= S_WB;
                    else             state_q <= S_FETCH;
                end
                S_MEM: begin
                    if (dmem_ready) state_q <= is_sw ? S_FETCH : S_WB;
                end
                S_WB:    state_q <= S_FETCH;
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    logic [ALU_OP_W-1:0] st_alu_op;
    logic [EXT_OP_W-1:0] st_ext_op;
    logic                st_alu_src;
    logic [1:0]          st_reg_dst;
    logic [1:0]          st_mem_to_reg;

    // Per-instruction datapath controls held through EXEC, MEM and WB
    always_comb begin
        st_alu_op     = '0;
        st_ext_op     = '0;
        st_alu_src    = 1'b0;
        st_reg_dst    = 2'd0;
        st_mem_to_reg = 2'd0;
        if (is_addu) begin
            st_reg_dst = 2'd1;
        end
        if (is_subu) begin
            st_alu_op  = ALU_OP_W'(1);
            st_reg_dst = 2'd1;
        end
        if (is_ori) begin
            st_alu_op  = ALU_OP_W'(2);
            st_alu_src = 1'b1;
        end
        if (is_lui) begin
            st_ext_op  = EXT_OP_W'(2);
            st_alu_src = 1'b1;
        end
        if (is_mem) begin
            st_ext_op  = EXT_OP_W'(1);
            st_alu_src = 1'b1;
        end
        if (is_lw) begin
            st_mem_to_reg = 2'd1;
        end
        if (is_beq) begin
            st_alu_op = ALU_OP_W'(3);
            st_ext_op = EXT_OP_W'(3);
        end
    end

    // Strobes decoded from state and IR; forced to 0 while reset is asserted
    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        npc_sel    = 2'd0;
        reg_write  = 1'b0;
        reg_dst    = 2'd0;
        mem_to_reg = 2'd0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        alu_op     = '0;
        ext_op     = '0;
        retire     = 1'b0;
        if (reset_n) begin
            if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
                alu_op     = st_alu_op;
                ext_op     = st_ext_op;
                alu_src    = st_alu_src;
                reg_dst    = st_reg_dst;
                mem_to_reg = st_mem_to_reg;
            end
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                S_DECODE: begin
                    if (is_j || is_jal) begin
                        pc_write = 1'b1;
                        npc_sel  = 2'd2;
                        retire   = 1'b1;
                    end
                    if (is_jal) begin
                        reg_write  = 1'b1;
                        reg_dst    = 2'd2;
                        mem_to_reg = 2'd2;
                    end
                    if (is_jr) begin
                        pc_write = 1'b1;
                        npc_sel  = 2'd3;
                        retire   = 1'b1;
                    end
                    if (is_nop) begin
                        retire = 1'b1;
                    end
                end
                S_EXEC: begin
                    if (is_beq) begin
                        pc_write = alu_zero;
                        npc_sel  = 2'd1;
                        retire   = 1'b1;
                    end
                end
                S_MEM: begin
                    dmem_req  = 1'b1;
                    mem_write = is_sw;
                    retire    = dmem_ready && is_sw;
                end
                S_WB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctl.sv
// tb/tb_mc_ctl.sv - self-checking bench for mc_ctl
module tb_mc_ctl;

    logic        clk, reset_n;
    logic [5:0]  opcode, func;
    logic        alu_zero, imem_ready, dmem_ready;
    logic        imem_req, dmem_req, ir_write, pc_write, reg_write, mem_write, alu_src, retire;
    logic [1:0]  npc_sel, reg_dst, mem_to_reg;
    logic [3:0]  alu_op, ext_op;
    logic [2:0]  state;
    logic [31:0] retire_cnt;

    mc_ctl dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .func(func), .alu_zero(alu_zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req), .dmem_req(dmem_req),
        .ir_write(ir_write), .pc_write(pc_write), .npc_sel(npc_sel), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .mem_write(mem_write), .alu_src(alu_src),
        .alu_op(alu_op), .ext_op(ext_op), .state(state), .retire(retire), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    localparam int SF = 0, SD = 1, SE = 2, SM = 3, SW_ = 4, SH = 5;
    localparam int C_ADDU = 0, C_SUBU = 1, C_JR = 2, C_LW = 3, C_SW = 4, C_ORI = 5,
                   C_LUI = 6, C_BEQ = 7, C_J = 8, C_JAL = 9, C_NOP = 10, C_ILL = 11;

    logic [8:0]  strobes;
    logic [12:0] statics;
    assign strobes = {imem_req, ir_write, dmem_req, mem_write, reg_write, pc_write, npc_sel, retire};
    assign statics = {alu_op, ext_op, alu_src, reg_dst, mem_to_reg};

    int vectors = 0;
    int miscompares = 0;
    int model_cnt = 0;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         iw;
        int         dw;
        logic       zero;
        int         cyc;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: case (fn)
                       6'h21: return C_ADDU;
                       6'h23: return C_SUBU;
                       6'h08: return C_JR;
                       6'h00: return C_NOP;
                       default: return C_ILL;
                   endcase
            6'h02: return C_J;
            6'h03: return C_JAL;
            6'h04: return C_BEQ;
            6'h0d: return C_ORI;
            6'h0f: return C_LUI;
            6'h23: return C_LW;
            6'h2b: return C_SW;
            default: return C_ILL;
        endcase
    endfunction

    // Zero-wait latency per class plus one cycle per wait
    function automatic int cyc_model(input int cls, input int iw, input int dw);
        case (cls)
            C_BEQ:                         return 3 + iw;
            C_ADDU, C_SUBU, C_ORI, C_LUI:  return 4 + iw;
            C_SW:                          return 4 + iw + dw;
            C_LW:                          return 5 + iw + dw;
            default:                       return 2 + iw;
        endcase
    endfunction

    function automatic logic [12:0] exp_static(input int cls);
        logic [3:0] a, e;
        logic       s;
        logic [1:0] rd, m2r;
        a = 0; e = 0; s = 0; rd = 0; m2r = 0;
        case (cls)
            C_ADDU: rd = 1;
            C_SUBU: begin a = 1; rd = 1; end
            C_ORI:  begin a = 2; s = 1; end
            C_LUI:  begin e = 2; s = 1; end
            C_LW:   begin e = 1; s = 1; m2r = 1; end
            C_SW:   begin e = 1; s = 1; end
            C_BEQ:  begin a = 3; e = 3; end
            default: ;
        endcase
        return {a, e, s, rd, m2r};
    endfunction

    // Runs one instruction from FETCH, checking every cycle against the phase list
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int iw, input int dw,
                             input logic zero, input int exp_cycles, input string tag);
        int q[$];
        int cls, es, fk, mk, ret_at;
        logic rdy_f;
        logic [1:0] e_npc;
        logic [8:0] e_str;
        logic [12:0] e_st;
        cls = classify(op, fn);
        if (cls == C_ILL) cls = C_NOP;
        for (int i = 0; i <= iw; i++) q.push_back(SF);
        q.push_back(SD);
        if (cls == C_BEQ) q.push_back(SE);
        if (cls == C_ADDU || cls == C_SUBU || cls == C_ORI || cls == C_LUI) begin
            q.push_back(SE); q.push_back(SW_);
        end
        if (cls == C_SW || cls == C_LW) begin
            q.push_back(SE);
            for (int i = 0; i <= dw; i++) q.push_back(SM);
            if (cls == C_LW) q.push_back(SW_);
        end
        opcode = op;
        func   = fn;
        fk = 0; mk = 0; ret_at = 0;
        for (int k = 0; k < q.size(); k++) begin
            es = q[k];
            imem_ready = (es == SF) ? (fk == iw) : 1'($urandom);
            dmem_ready = (es == SM) ? (mk == dw) : 1'($urandom);
            alu_zero   = (es == SE) ? zero : 1'($urandom);
            #1;
            rdy_f = (es == SF) && (fk == iw);
            e_npc = 2'd0;
            if (es == SD && (cls == C_J || cls == C_JAL)) e_npc = 2'd2;
            if (es == SD && cls == C_JR) e_npc = 2'd3;
            if (es == SE && cls == C_BEQ) e_npc = 2'd1;
            e_str = {es == SF, rdy_f, es == SM, es == SM && cls == C_SW,
                     es == SW_ || (es == SD && cls == C_JAL),
                     rdy_f || (es == SD && (cls == C_J || cls == C_JAL || cls == C_JR)) ||
                         (es == SE && cls == C_BEQ && zero),
                     e_npc, k == q.size() - 1};
            e_st = 13'd0;
            if (es == SE || es == SM || es == SW_) e_st = exp_static(cls);
            if (es == SD && cls == C_JAL) e_st = {9'd0, 2'd2, 2'd2};
            chk($sformatf("%s state c%0d", tag, k), int'(state), es);
            chk($sformatf("%s strobes c%0d", tag, k), int'(strobes), int'(e_str));
            chk($sformatf("%s statics c%0d", tag, k), int'(statics), int'(e_st));
            if (retire && ret_at == 0) ret_at = k + 1;
            if (es == SF) fk++;
            if (es == SM) mk++;
            @(negedge clk);
        end
        model_cnt++;
        chk({tag, " cycles"}, ret_at, exp_cycles);
        chk({tag, " end state"}, int'(state), SF);
        chk({tag, " retire_cnt"}, int'(retire_cnt), model_cnt);
    endtask

    vec_t tbl[$];
    logic [11:0] pool [13];

    initial begin
        int n_pool, idx, iw, dw, cls;
        clk = 0; reset_n = 0; opcode = 6'h2b; func = 0;
        alu_zero = 0; imem_ready = 1; dmem_ready = 0;
        #1;
        chk("reset strobes", int'(strobes), 0);
        chk("reset statics", int'(statics), 0);
        chk("reset state", int'(state), 0);
        chk("reset retire_cnt", int'(retire_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;

        tbl.push_back('{6'h00, 6'h21, 0, 0, 1'b0, 4});
        tbl.push_back('{6'h23, 6'h00, 2, 3, 1'b0, 10});
        tbl.push_back('{6'h04, 6'h00, 0, 0, 1'b1, 3});
        tbl.push_back('{6'h04, 6'h00, 0, 0, 1'b0, 3});
        tbl.push_back('{6'h03, 6'h00, 0, 0, 1'b0, 2});
        tbl.push_back('{6'h02, 6'h00, 1, 0, 1'b0, 3});
        tbl.push_back('{6'h00, 6'h08, 0, 0, 1'b0, 2});
        tbl.push_back('{6'h2b, 6'h00, 0, 0, 1'b0, 4});
        tbl.push_back('{6'h2b, 6'h00, 0, 2, 1'b0, 6});
        tbl.push_back('{6'h0d, 6'h00, 0, 0, 1'b0, 4});
        tbl.push_back('{6'h0f, 6'h00, 0, 0, 1'b0, 4});
        tbl.push_back('{6'h00, 6'h23, 1, 0, 1'b0, 5});
        tbl.push_back('{6'h00, 6'h00, 0, 0, 1'b0, 2});
        tbl.push_back('{6'h23, 6'h00, 0, 0, 1'b0, 5});
        foreach (tbl[i])
            run_instr(tbl[i].op, tbl[i].fn, tbl[i].iw, tbl[i].dw, tbl[i].zero, tbl[i].cyc,
                      $sformatf("tbl%0d", i));

`ifdef MC_CTL_ILLEGAL_TRAP_EN
        opcode = 6'h3f; func = 0; imem_ready = 1;
        @(negedge clk);
        #1;
        chk("ill decode state", int'(state), SD);
        chk("ill decode retire", int'(retire), 0);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            imem_ready = 1'($urandom); dmem_ready = 1'($urandom);
            #1;
            chk($sformatf("halt state c%0d", k), int'(state), SH);
            chk($sformatf("halt strobes c%0d", k), int'(strobes), 0);
            chk($sformatf("halt retire_cnt c%0d", k), int'(retire_cnt), model_cnt);
            @(negedge clk);
        end
        reset_n = 0;
        #1;
        chk("halt reset state", int'(state), SF);
        @(negedge clk);
        reset_n = 1;
        model_cnt = 0;
`else
        run_instr(6'h3f, 6'h00, 0, 0, 1'b0, 2, "unk op");
        run_instr(6'h00, 6'h3f, 0, 0, 1'b0, 2, "unk func");
`endif

        opcode = 6'h2b; func = 0; imem_ready = 1; dmem_ready = 0;
        @(negedge clk);
        imem_ready = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mid-mem state", int'(state), SM);
        chk("mid-mem mem_write", int'(mem_write), 1);
        reset_n = 0;
        #1;
        chk("async reset mem_write", int'(mem_write), 0);
        chk("async reset dmem_req", int'(dmem_req), 0);
        chk("async reset state", int'(state), SF);
        @(negedge clk);
        reset_n = 1;
        #1;
        chk("post reset state", int'(state), SF);
        chk("post reset retire_cnt", int'(retire_cnt), 0);
        model_cnt = 0;
        @(negedge clk);

        pool = '{12'h021, 12'h023, 12'h008, 12'h8c0, 12'hac0, 12'h340, 12'h3c0,
                 12'h100, 12'h080, 12'h0c0, 12'h000, 12'hfc0, 12'h03f};
`ifdef MC_CTL_ILLEGAL_TRAP_EN
        n_pool = 11;
`else
        n_pool = 13;
`endif
        for (int r = 0; r < 40; r++) begin
            idx = $urandom_range(n_pool - 1, 0);
            iw  = $urandom_range(3, 0);
            dw  = $urandom_range(3, 0);
            cls = classify(pool[idx][11:6], pool[idx][5:0]);
            run_instr(pool[idx][11:6], pool[idx][5:0], iw, dw, 1'($urandom),
                      cyc_model(cls, iw, dw), $sformatf("rnd%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
